// File: rtl/vdp_cpu_port.sv
// CPU-side VDP port: decodes Z80 control/data accesses into VRAM/CRAM/register writes and read-ahead.
// Latency: memory strobes one cycle after the CPU strobe; read-ahead data lands in read_buf at T+2.
// Backpressure: none; CPU strobes that arrive while a read-ahead is in flight are dropped.
module vdp_cpu_port #(
  parameter bit GG_MODE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic        io_ctrl,
  input  logic [7:0]  io_di,
  output logic [7:0]  io_do,
  output logic [13:0] vram_a,
  output logic [7:0]  vram_do,
  output logic        vram_we,
  output logic        vram_re,
  input  logic [7:0]  vram_di,
  output logic [4:0]  cram_a,
  output logic [11:0] cram_do,
  output logic        cram_we,
  input  logic        vblank_pulse,
  output logic [7:0]  scroll_x,
  output logic [7:0]  scroll_y,
  output logic        disable_x_scroll,
  output logic        disable_y_scroll,
  output logic [13:0] name_table_addr,
  output logic        display_en,
  output logic        irq_n
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAP} state_t;

  state_t      state_q;
  logic [13:0] addr_q;
  logic [1:0]  code_q;
  logic        latch_full_q;
  logic [7:0]  read_buf_q;
  logic [7:0]  cram_lsb_q;
  logic        vsync_flag_q;
  logic [7:0]  regs_q [0:10];

  logic [7:0]  io_do_q;
  logic [13:0] vram_a_q;
  logic [7:0]  vram_do_q;
  logic        vram_we_q;
  logic        vram_re_q;
  logic [4:0]  cram_a_q;
  logic [11:0] cram_do_q;
  logic        cram_we_q;

  logic        ctrl_wr, data_wr, ctrl_rd, data_rd;
  logic [13:0] addr_ctl_d;
  logic [13:0] addr_inc_d;
  logic        vsync_flag_d;

  // Strobe decode: only accepted in IDLE; a write in the same cycle as a read wins.
  always_comb begin
    ctrl_wr      = 1'b0;
    data_wr      = 1'b0;
    ctrl_rd      = 1'b0;
    data_rd      = 1'b0;
    if (state_q == S_IDLE) begin
      ctrl_wr = io_wr & io_ctrl;
      data_wr = io_wr & ~io_ctrl;
      ctrl_rd = io_rd & ~io_wr & io_ctrl;
      data_rd = io_rd & ~io_wr & ~io_ctrl;
    end
    addr_ctl_d   = {io_di[5:0], addr_q[7:0]};
    addr_inc_d   = addr_q + 14'd1;
    // vblank has priority so a flag raised during a status read is not lost.
    vsync_flag_d = vblank_pulse | (vsync_flag_q & ~ctrl_rd);
  end

  // Access sequencer: port decode in IDLE, then the two-cycle VRAM read-ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      code_q       <= '0;
      latch_full_q <= 1'b0;
      read_buf_q   <= '0;
      cram_lsb_q   <= '0;
      vsync_flag_q <= 1'b0;
      for (int i = 0; i <= 10; i++) regs_q[i] <= '0;
      io_do_q      <= '0;
      vram_a_q     <= '0;
      vram_do_q    <= '0;
      vram_we_q    <= 1'b0;
      vram_re_q    <= 1'b0;
      cram_a_q     <= '0;
      cram_do_q    <= '0;
      cram_we_q    <= 1'b0;
    end else begin
      vram_we_q    <= 1'b0;
      vram_re_q    <= 1'b0;
      cram_we_q    <= 1'b0;
      vsync_flag_q <= vsync_flag_d;
      case (state_q)
        S_IDLE: begin
          if (ctrl_wr) begin
            if (!latch_full_q) begin
              addr_q[7:0]  <= io_di;
              latch_full_q <= 1'b1;
            end else begin
              code_q       <= io_di[7:6];
              addr_q       <= addr_ctl_d;
              latch_full_q <= 1'b0;
              // Register write: the data byte is the first control byte (addr low).
              if (io_di[7:6] == 2'd2 && io_di[3:0] <= 4'd10)
                regs_q[io_di[3:0]] <= addr_q[7:0];
              if (io_di[7:6] == 2'd0) begin
                state_q   <= S_REQ;
                vram_re_q <= 1'b1;
                vram_a_q  <= addr_ctl_d;
              end
            end
          end else if (data_wr) begin
            latch_full_q <= 1'b0;
            read_buf_q   <= io_di;
            addr_q       <= addr_inc_d;
            if (code_q != 2'd3) begin
              vram_we_q <= 1'b1;
              vram_a_q  <= addr_q;
              vram_do_q <= io_di;
            end else if (GG_MODE) begin
              // Even byte is parked; the odd byte commits the full 12-bit word.
              if (!addr_q[0]) begin
                cram_lsb_q <= io_di;
              end else begin
                cram_we_q <= 1'b1;
                cram_a_q  <= addr_q[5:1];
                cram_do_q <= {io_di[3:0], cram_lsb_q};
              end
            end else begin
              cram_we_q <= 1'b1;
              cram_a_q  <= addr_q[4:0];
              cram_do_q <= {6'b0, io_di[5:0]};
            end
          end else if (data_rd) begin
            io_do_q      <= read_buf_q;
            latch_full_q <= 1'b0;
            state_q      <= S_REQ;
            vram_re_q    <= 1'b1;
            vram_a_q     <= addr_q;
          end else if (ctrl_rd) begin
            io_do_q      <= {vsync_flag_q, 7'b0};
            latch_full_q <= 1'b0;
          end
        end
        S_REQ: begin
          addr_q  <= addr_inc_d;
          state_q <= S_CAP;
        end
        S_CAP: begin
          read_buf_q <= vram_di;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io_do            = io_do_q;
  assign vram_a           = vram_a_q;
  assign vram_do          = vram_do_q;
  assign vram_we          = vram_we_q;
  assign vram_re          = vram_re_q;
  assign cram_a           = cram_a_q;
  assign cram_do          = cram_do_q;
  assign cram_we          = cram_we_q;
  assign scroll_x         = regs_q[8];
  assign scroll_y         = regs_q[9];
  assign disable_x_scroll = regs_q[0][6];
  assign disable_y_scroll = regs_q[0][7];
  assign name_table_addr  = {regs_q[2][3:1], 11'b0};
  assign display_en       = regs_q[1][6];
  assign irq_n            = ~(vsync_flag_q & regs_q[1][5]);

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port (GG_MODE=1) with a small VRAM model and strobe monitors.
// Inputs change on negedge; outputs are checked on negedge, away from the active edge.
// Memory strobes are logged into queues and compared against hand-computed addresses/data.
module tb_vdp_cpu_port;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_wr, io_rd, io_ctrl;
  logic [7:0]  io_di, io_do;
  logic [13:0] vram_a;
  logic [7:0]  vram_do, vram_di;
  logic        vram_we, vram_re;
  logic [4:0]  cram_a;
  logic [11:0] cram_do;
  logic        cram_we;
  logic        vblank_pulse;
  logic [7:0]  scroll_x, scroll_y;
  logic        disable_x_scroll, disable_y_scroll;
  logic [13:0] name_table_addr;
  logic        display_en, irq_n;

  int checks = 0;
  int errors = 0;
  int re_cnt = 0;
  int n;
  logic [13:0] we_a [$];
  logic [7:0]  we_d [$];
  logic [4:0]  cw_a [$];
  logic [11:0] cw_d [$];
  logic [7:0]  mem [0:16383];

  vdp_cpu_port #(.GG_MODE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .io_wr(io_wr), .io_rd(io_rd), .io_ctrl(io_ctrl),
    .io_di(io_di), .io_do(io_do), .vram_a(vram_a), .vram_do(vram_do), .vram_we(vram_we),
    .vram_re(vram_re), .vram_di(vram_di), .cram_a(cram_a), .cram_do(cram_do),
    .cram_we(cram_we), .vblank_pulse(vblank_pulse), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .disable_x_scroll(disable_x_scroll), .disable_y_scroll(disable_y_scroll),
    .name_table_addr(name_table_addr), .display_en(display_en), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  // VRAM model: synchronous write, read data valid the cycle after vram_re.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_di <= 8'h00;
      mem[14'h1000] <= 8'h12;
      mem[14'h1001] <= 8'h34;
    end else begin
      if (vram_we) mem[vram_a] <= vram_do;
      if (vram_re) vram_di <= mem[vram_a];
    end
  end

  // Strobe monitors, one sample per cycle.
  always @(negedge clk) begin
    if (vram_we) begin we_a.push_back(vram_a); we_d.push_back(vram_do); end
    if (cram_we) begin cw_a.push_back(cram_a); cw_d.push_back(cram_do); end
    if (vram_re) re_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic c, input logic [7:0] d);
    @(negedge clk);
    io_wr = 1'b1; io_ctrl = c; io_di = d;
    @(negedge clk);
    io_wr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic rd(input logic c);
    @(negedge clk);
    io_rd = 1'b1; io_ctrl = c;
    @(negedge clk);
    io_rd = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; io_wr = 1'b0; io_rd = 1'b0; io_ctrl = 1'b0; io_di = 8'h00; vblank_pulse = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_io_do", 16'(io_do), 16'h00);
    chk("rst_irq_n", 16'(irq_n), 16'h1);
    chk("rst_vram_we", 16'(vram_we), 16'h0);
    chk("rst_vram_a", 16'(vram_a), 16'h0000);
    chk("rst_nt_addr", 16'(name_table_addr), 16'h0000);
    chk("rst_scroll_x", 16'(scroll_x), 16'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // VRAM writes with auto-increment
    wr(1'b1, 8'h00); wr(1'b1, 8'h40);
    wr(1'b0, 8'hAA); wr(1'b0, 8'h55); wr(1'b0, 8'h77);
    chk("vw_count", 16'(we_a.size()), 16'd3);
    chk("vw0_a", 16'(we_a[0]), 16'h0000);
    chk("vw0_d", 16'(we_d[0]), 16'h00AA);
    chk("vw1_a", 16'(we_a[1]), 16'h0001);
    chk("vw1_d", 16'(we_d[1]), 16'h0055);
    chk("vw2_a_addr_end", 16'(we_a[2]), 16'h0002);
    chk("vw_no_re", 16'(re_cnt), 16'd0);

    // Register writes
    wr(1'b1, 8'h34); wr(1'b1, 8'h88);
    chk("scroll_x", 16'(scroll_x), 16'h34);
    wr(1'b1, 8'h07); wr(1'b1, 8'h82);
    chk("nt_addr_07", 16'(name_table_addr), 16'h1800);
    wr(1'b1, 8'h0E); wr(1'b1, 8'h82);
    chk("nt_addr_0e", 16'(name_table_addr), 16'h3800);
    wr(1'b1, 8'hFF); wr(1'b1, 8'h8F);
    chk("r15_ign_sx", 16'(scroll_x), 16'h34);
    chk("r15_ign_nt", 16'(name_table_addr), 16'h3800);
    wr(1'b1, 8'h66); wr(1'b1, 8'h8B);
    chk("r11_ign_sx", 16'(scroll_x), 16'h34);
    wr(1'b1, 8'hC0); wr(1'b1, 8'h80);
    chk("dis_x", 16'(disable_x_scroll), 16'h1);
    chk("dis_y", 16'(disable_y_scroll), 16'h1);
    wr(1'b1, 8'h9A); wr(1'b1, 8'h89);
    chk("scroll_y", 16'(scroll_y), 16'h9A);

    // Read-ahead
    wr(1'b1, 8'h00); wr(1'b1, 8'h10);
    chk("ra_re_count", 16'(re_cnt), 16'd1);
    rd(1'b0);
    chk("ra_rd0", 16'(io_do), 16'h12);
    rd(1'b0);
    chk("ra_rd1", 16'(io_do), 16'h34);
    chk("ra_re_count3", 16'(re_cnt), 16'd3);

    // Simultaneous write and read: write wins
    wr(1'b1, 8'h00); wr(1'b1, 8'h41);
    n = we_a.size();
    @(negedge clk);
    io_wr = 1'b1; io_rd = 1'b1; io_ctrl = 1'b0; io_di = 8'h5A;
    @(negedge clk);
    io_wr = 1'b0; io_rd = 1'b0;
    repeat (4) @(negedge clk);
    chk("wr_rd_count", 16'(we_a.size()), 16'(n + 1));
    chk("wr_rd_a", 16'(we_a[n]), 16'h0100);
    chk("wr_rd_d", 16'(we_d[n]), 16'h005A);
    chk("wr_rd_io_do", 16'(io_do), 16'h34);
    chk("wr_rd_no_re", 16'(re_cnt), 16'd3);

    // GG CRAM word write
    n = we_a.size();
    wr(1'b1, 8'h02); wr(1'b1, 8'hC0);
    wr(1'b0, 8'h0F);
    chk("cram_lsb_no_we", 16'(cw_a.size()), 16'd0);
    wr(1'b0, 8'h0A);
    chk("cram_count", 16'(cw_a.size()), 16'd1);
    chk("cram_a", 16'(cw_a[0]), 16'h0001);
    chk("cram_do", 16'(cw_d[0]), 16'h0A0F);
    chk("cram_no_vram", 16'(we_a.size()), 16'(n));

    // Address wrap
    n = we_a.size();
    wr(1'b1, 8'hFF); wr(1'b1, 8'h7F);
    wr(1'b0, 8'h01); wr(1'b0, 8'h02);
    chk("wrap_count", 16'(we_a.size()), 16'(n + 2));
    chk("wrap_a0", 16'(we_a[n]), 16'h3FFF);
    chk("wrap_a1", 16'(we_a[n + 1]), 16'h0000);
    chk("wrap_d1", 16'(we_d[n + 1]), 16'h0002);

    // Vsync flag / IRQ
    wr(1'b1, 8'h20); wr(1'b1, 8'h81);
    chk("irq_idle", 16'(irq_n), 16'h1);
    chk("display_en", 16'(display_en), 16'h0);
    @(negedge clk); vblank_pulse = 1'b1;
    @(negedge clk); vblank_pulse = 1'b0;
    @(negedge clk);
    chk("irq_asserted", 16'(irq_n), 16'h0);
    rd(1'b1);
    chk("stat_rd", 16'(io_do), 16'h80);
    chk("irq_cleared", 16'(irq_n), 16'h1);
    @(negedge clk);
    io_rd = 1'b1; io_ctrl = 1'b1; vblank_pulse = 1'b1;
    @(negedge clk);
    io_rd = 1'b0; vblank_pulse = 1'b0;
    repeat (4) @(negedge clk);
    chk("stat_race_rd", 16'(io_do), 16'h00);
    chk("stat_race_irq", 16'(irq_n), 16'h0);
    rd(1'b1);
    chk("stat_rd2", 16'(io_do), 16'h80);

    // Data read clears a half-written control latch
    wr(1'b1, 8'h12);
    rd(1'b0);
    wr(1'b1, 8'h56); wr(1'b1, 8'h88);
    chk("latch_clear_sx", 16'(scroll_x), 16'h56);

    // Reset in the middle of a read-ahead
    @(negedge clk);
    io_rd = 1'b1; io_ctrl = 1'b0;
    @(negedge clk);
    io_rd = 1'b0;
    chk("mid_re_seen", 16'(vram_re), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_re", 16'(vram_re), 16'h0);
    chk("mid_rst_sx", 16'(scroll_x), 16'h00);
    chk("mid_rst_io_do", 16'(io_do), 16'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
